// File: rtl/ct_spsram_acc_pkg.sv
// ct_spsram_acc_pkg: shared state encoding, default widths and byte-enable expansion for the SRAM access controller.
package ct_spsram_acc_pkg;
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_RSP_DEPTH  = 3;
  function automatic logic [DEF_DATA_WIDTH-1:0] be2wen(input logic [DEF_DATA_WIDTH/8-1:0] be);
    logic [DEF_DATA_WIDTH-1:0] wen;
    for (int i = 0; i < DEF_DATA_WIDTH; i++) wen[i] = ~be[i/8];
    return wen;
  endfunction
endpackage

// File: rtl/ct_spsram_acc_rspfifo.sv
// ct_spsram_acc_rspfifo: small synchronous FIFO holding read data until the requester accepts it.
module ct_spsram_acc_rspfifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 128,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_cnt,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_wp_nxt, w_rp_nxt;
  assign w_wp_nxt = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
  assign w_rp_nxt = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= w_wp_nxt;
      if (i_pop) r_rp <= w_rp_nxt;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end
  assign o_rdata = r_mem[r_rp];
  assign o_cnt   = r_cnt;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/ct_spsram_acc_ctrl.sv
// ct_spsram_acc_ctrl: request/response front end for the single-port data SRAM with post-reset zero fill.
import ct_spsram_acc_pkg::*;
module ct_spsram_acc_ctrl #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int INIT_EN    = 1
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  state_t                    r_state, w_nxt_state;
  logic [ADDR_WIDTH-1:0]     r_cnt;
  logic                      r_rd_inflight;
  logic                      r_init_done;
  logic [CW-1:0]             w_fifo_cnt;
  logic [CW:0]               w_used;
  logic                      w_fifo_full, w_fifo_empty;
  logic                      w_acc, w_rd, w_wr, w_pop;
  logic [DEF_DATA_WIDTH/8-1:0] w_be_ext;
  logic [DEF_DATA_WIDTH-1:0]   w_wen_all;
  // read credit covers both queued data and the read still inside the SRAM
  assign w_used    = {1'b0, w_fifo_cnt} + (CW + 1)'(r_rd_inflight);
  assign req_rdy   = (r_state == RUN) & (w_used < (CW + 1)'(RSP_DEPTH));
  assign w_acc     = req_vld & req_rdy;
  assign w_rd      = w_acc & ~req_wr;
  assign w_wr      = w_acc & req_wr & (|req_be);
  assign rsp_vld   = ~w_fifo_empty;
  assign w_pop     = rsp_vld & rsp_rdy;
  assign init_done = r_init_done;
  assign w_wen_all = be2wen(w_be_ext);
  always_comb begin
    w_be_ext = '0;
    w_be_ext[DATA_WIDTH/8-1:0] = req_be;
  end
  always_comb begin
    w_nxt_state = r_state;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_d      = '0;
    sram_a      = '0;
    if (r_state == IDLE) w_nxt_state = (INIT_EN != 0) ? INIT : RUN;
    if (r_state == INIT) begin
      w_nxt_state = (&r_cnt) ? RUN : INIT;
      sram_cen    = 1'b0;
      sram_gwen   = 1'b0;
      sram_wen    = '0;
      sram_a      = r_cnt;
    end else if (w_rd | w_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = ~w_wr;
      sram_wen  = w_wr ? w_wen_all[DATA_WIDTH-1:0] : '1;
      sram_d    = w_wr ? req_wdata : '0;
      sram_a    = req_addr;
    end
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rd_inflight <= 1'b0;
      r_init_done   <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= (r_state == INIT) ? r_cnt + ADDR_WIDTH'(1) : '0;
      r_rd_inflight <= w_rd;
      r_init_done   <= w_nxt_state == RUN;
    end
  end
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b) assert (!(r_rd_inflight && w_fifo_full && !w_pop));
  end
  ct_spsram_acc_rspfifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_rspfifo (
    .i_clk   (forever_cpuclk),
    .i_rst_n (cpurst_b),
    .i_push  (r_rd_inflight),
    .i_pop   (w_pop),
    .i_wdata (sram_q),
    .o_rdata (rsp_rdata),
    .o_cnt   (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
endmodule

// File: tb/tb_ct_spsram_acc_ctrl.sv
// tb_ct_spsram_acc_ctrl: SRAM model plus in-order read scoreboard around the access controller.
module tb_ct_spsram_acc_ctrl;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  logic clk = 0, rst_n = 0;
  logic req_vld = 0, req_wr = 0, rsp_rdy = 1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic req_rdy, rsp_vld, init_done, sram_cen, sram_gwen;
  logic [DW-1:0] rsp_rdata, sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_mem [2**AW];
  logic [DW-1:0] sb [$];
  logic held = 0;
  logic [DW-1:0] held_data;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ct_spsram_acc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(3), .INIT_EN(1)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );
  initial for (int i = 0; i < 2**AW; i++) mem[i] <= {$urandom, $urandom, $urandom, $urandom};
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= mem[sram_a];
    end
  end
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (held) chk("rsp_hold", rsp_rdata, held_data);
      held = rsp_vld & ~rsp_rdy;
      held_data = rsp_rdata;
      if (req_vld && req_rdy) begin
        if (!req_wr) sb.push_back(exp_mem[req_addr]);
        else for (int b = 0; b < BW; b++) if (req_be[b]) exp_mem[req_addr][b*8+:8] = req_wdata[b*8+:8];
      end
      if (rsp_vld && rsp_rdy) begin
        if (sb.size() == 0) chk("rsp_extra", sb.size(), 1);
        else chk("rsp_data", rsp_rdata, sb.pop_front());
      end
    end else held = 0;
  end
  task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    @(posedge clk); #1;
    req_vld = 1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
  endtask
  task automatic idle();
    @(posedge clk); #1;
    req_vld = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    int k = 0;
    drive(wr, a, d, be);
    @(negedge clk);
    while (!req_rdy && k < 50) begin @(negedge clk); k++; end
    chk("req_accept", req_rdy, 1);
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
    chk("drain", sb.size(), 0);
  endtask
  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end
  initial begin
    int k;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_flags", {req_rdy, rsp_vld, init_done}, 3'b000);
    chk("rst_ctl", {sram_cen, sram_gwen}, 2'b11);
    chk("rst_wen", sram_wen, '1);
    chk("rst_da", {sram_d, sram_a}, 0);
    rst_n = 1;
    chk("idle_cen", {sram_cen, req_rdy}, 2'b10);
    for (int i = 0; i < 2**AW; i++) begin
      @(negedge clk);
      chk("init_pins", {sram_cen, sram_gwen, req_rdy, init_done, sram_a}, {4'b0000, 4'(i)});
      chk("init_wd", {sram_wen, sram_d}, 0);
    end
    @(negedge clk);
    chk("init_done", {init_done, req_rdy, sram_cen}, 3'b111);
    drive(1, 5, {16{8'hA5}}, 16'hFFFF);
    @(negedge clk);
    chk("wr_pins", {req_rdy, sram_cen, sram_gwen, sram_a}, {3'b100, 4'd5});
    chk("wr_wen", sram_wen, 0);
    chk("wr_d", sram_d, {16{8'hA5}});
    drive(0, 5, 0, 0);
    @(negedge clk);
    chk("rd_pins", {req_rdy, sram_cen, sram_gwen, sram_a}, {3'b101, 4'd5});
    chk("rd_wen", sram_wen, '1);
    idle();
    @(negedge clk);
    chk("rd_lat1", {rsp_vld, sram_cen, sram_a}, {2'b01, 4'd0});
    @(negedge clk);
    chk("rd_lat2", rsp_vld, 1);
    chk("rd_data", rsp_rdata, {16{8'hA5}});
    drive(1, 3, '1, 16'h0001);
    @(negedge clk);
    chk("pw_wen", sram_wen, {{120{1'b1}}, 8'h00});
    chk("pw_d", sram_d, '1);
    drive(0, 3, 0, 0);
    idle();
    repeat (2) @(negedge clk);
    chk("pw_vld", rsp_vld, 1);
    chk("pw_data", rsp_rdata, 128'hFF);
    drive(1, 3, '1, 16'h0000);
    @(negedge clk);
    chk("be0_cen", {req_rdy, sram_cen, sram_gwen}, 3'b111);
    xfer(1, 1, {4{32'h1111_0001}}, '1);
    xfer(1, 2, {4{32'h2222_0002}}, '1);
    xfer(1, 4, {4{32'h4444_0004}}, 16'hF0F0);
    xfer(1, 0, {4{32'hDEAD_BEEF}}, '1);
    xfer(0, 3, 0, 0);
    idle();
    drain();
    @(posedge clk); #1 rsp_rdy = 0;
    for (int a = 1; a <= 4; a++) begin
      drive(0, 4'(a), 0, 0);
      @(negedge clk);
      chk("bp_rdy", req_rdy, a < 4);
    end
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", {req_rdy, rsp_vld}, 2'b01);
    end
    @(posedge clk); #1 rsp_rdy = 1;
    @(negedge clk);
    chk("bp_pop_rdy", req_rdy, 0);
    @(negedge clk);
    chk("bp_acc4", req_rdy, 1);
    idle();
    drain();
    for (int i = 0; i < 8; i++) begin
      drive(0, 4'(i), 0, 0);
      @(negedge clk);
      chk("st_rdy", req_rdy, 1);
      if (i >= 2) chk("st_vld", rsp_vld, 1);
    end
    idle();
    @(negedge clk);
    chk("st_vld_t8", rsp_vld, 1);
    @(negedge clk);
    chk("st_vld_t9", rsp_vld, 1);
    @(negedge clk);
    chk("st_end", rsp_vld, 0);
    @(posedge clk); #1;
    rst_n = 0;
    clear_model();
    req_vld = 1; req_wr = 0; req_addr = 0;
    #1 chk("rst2_flags", {sram_cen, req_rdy, rsp_vld, init_done}, 4'b1000);
    @(negedge clk) rst_n = 1;
    k = 0;
    @(negedge clk);
    while (!(sram_a == 7 && !sram_cen) && k < 20) begin @(negedge clk); k++; end
    chk("init_at7", {sram_cen, sram_a}, {1'b0, 4'd7});
    #1 rst_n = 0;
    clear_model();
    #1 chk("midinit_rst", {sram_cen, sram_gwen, req_rdy, init_done, rsp_vld, sram_a}, {5'b11000, 4'd0});
    chk("midinit_wen", sram_wen, '1);
    @(negedge clk) rst_n = 1;
    chk("restart_idle", sram_cen, 1);
    @(negedge clk);
    chk("restart_a0", {sram_cen, sram_a}, {1'b0, 4'd0});
    @(negedge clk);
    chk("restart_a1", {sram_cen, sram_a}, {1'b0, 4'd1});
    k = 0;
    while (!init_done && k < 40) begin @(negedge clk); k++; end
    chk("reinit_done", {init_done, req_rdy}, 2'b11);
    idle();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ct_spsram_acc_ctrl.md
Name: ct_spsram_acc_ctrl

Overview:
Access controller that sits directly upstream of the 32768x128 single-port data SRAM wrapper. It drives the SRAM's A/CEN/GWEN/WEN/D pins and takes its Q output. It accepts read and write requests over a valid/ready handshake, clears the array to zero after reset, and buffers read data in an in-order response FIFO with backpressure. All SRAM control pins are active-low, matching the SRAM wrapper; the write mask is per bit.

Parameters:
ADDR_WIDTH, 15, SRAM address width (benches may shrink it to speed up init).
DATA_WIDTH, 128, data width; must be a multiple of 8.
RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 gives full read throughput.
INIT_EN, 1, 1 = zero-fill the whole array after reset; 0 = go straight to RUN.

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  reset, asynchronous, active-low
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables, active-high
rsp_vld  out  1  read data valid
rsp_rdy  in  1  read data accepted
rsp_rdata  out  DATA_WIDTH  read data
init_done  out  1  array cleared; controller in RUN
sram_a  out  ADDR_WIDTH  to SRAM A
sram_cen  out  1  to SRAM CEN, active-low
sram_gwen  out  1  to SRAM GWEN, 0 = write
sram_wen  out  DATA_WIDTH  to SRAM WEN, per-bit, active-low
sram_d  out  DATA_WIDTH  to SRAM D
sram_q  in  DATA_WIDTH  from SRAM Q; valid the cycle after a read access

Behaviour:
- Clock and reset: one clock, forever_cpuclk; reset cpurst_b is asynchronous, active-low.
- Values while in reset: FSM=IDLE; req_rdy=0, rsp_vld=0, init_done=0, sram_cen=1, sram_gwen=1, sram_wen all 1, sram_d=0, sram_a=0; FIFO empty; rd_inflight=0.
- FSM states: IDLE, INIT, RUN.
  - IDLE: lasts one cycle after reset release; goes to INIT if INIT_EN=1, else to RUN.
  - INIT: 15-bit (ADDR_WIDTH) counter runs 0 to 2^ADDR_WIDTH-1, one address per cycle. Each cycle drives sram_cen=0, sram_gwen=0, sram_wen all 0, sram_d=0, sram_a=counter. After the max address is written, next state is RUN. req_rdy=0 throughout INIT.
  - RUN: terminal state; init_done=1 (registered, equals state==RUN).
- Request acceptance: accept = req_vld & req_rdy. SRAM pins are driven combinationally from the accepted request in the same cycle; the access happens at that cycle's closing edge.
  - Read: cen=0, gwen=1, wen all 1, d=0.
  - Write: cen=0, gwen=0, wen[i] = ~req_be[i/8], d=req_wdata.
  - Write with req_be=0: accepted but no access is made (cen=1). Writes produce no response.
  - No accept: cen=1, gwen=1, wen all 1, d=0, a=0.
- Ready rule: req_rdy = (state==RUN) & (fifo_cnt + rd_inflight < RSP_DEPTH). It does not depend on req_wr or rsp_rdy, so no combinational ready-to-ready path. Writes also stall when the credit is exhausted.
- Read pipeline:
  - Cycle T: read accepted; rd_inflight is set at the end of T.
  - Cycle T+1: sram_q is pushed into the FIFO at the end of T+1.
  - Cycle T+2: earliest rsp_vld. Read latency is 2 cycles minimum.
  - Responses are returned strictly in order.
- FIFO:
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - rsp_rdata is held stable while rsp_vld & ~rsp_rdy.
  - Overflow is impossible by the credit rule; an assertion checks it.
- Read-after-write to the same address in consecutive cycles returns the new data, because SRAM accesses are sequential.
- Reset asserted mid-INIT or mid-traffic: the asynchronous clear applies. Counter, FIFO contents and the in-flight read are discarded. INIT restarts from address 0.

Decomposition:
- Shared package ct_spsram_acc_pkg holds:
  - state enum {IDLE, INIT, RUN};
  - default width constants;
  - function be2wen (byte enable to active-low bit mask).
- Sub-module ct_spsram_acc_rspfifo: parameterised synchronous FIFO (DEPTH, WIDTH) with push, pop, cnt, full and empty.

Test Plan:
- Init: ADDR_WIDTH=4, release reset → 1 IDLE cycle, then 16 cycles with cen=0, gwen=0, a=0..15, d=0 → init_done=1 in the next cycle; req_rdy=0 until then.
- Full write then read: write addr 5, data 128'hA5A5…A5, be=16'hFFFF; read addr 5 the next cycle → rsp_vld 2 cycles after the read accept, rsp_rdata=A5…A5.
- Partial write: after init, write addr 3, data all-F, be=16'h0001 → sram_wen={120'h all ones, 8'h00}; reading addr 3 returns 128'h…00FF.
- Backpressure: rsp_rdy=0, back-to-back reads of addrs 1, 2, 3, 4 → exactly 3 accepted, then req_rdy=0. Raise rsp_rdy → data for 1, 2, 3 returned in order; addr 4 then accepted.
- Streaming: rsp_rdy=1, 8 consecutive reads → one accept per cycle, 8 responses on consecutive cycles with no bubbles.
- Reset mid-INIT: drop cpurst_b at counter=7 with reads pending → outputs go to reset values immediately; INIT restarts at a=0.
